// File: rtl/ebike_pkg.sv
// Shared e-bike control definitions: cadence FSM states, saturation codes and
// prescaler widths for simulation-speed and real-time builds.
package ebike_pkg;

    typedef enum logic [1:0] {
        CAD_IDLE  = 2'd0,
        CAD_MEAS  = 2'd1,
        CAD_STALL = 2'd2
    } cad_state_t;

    localparam logic [7:0] CAD_SAT = 8'hFF;
    localparam logic [7:0] CAD_MAX = 8'hFE;

    localparam int PRESCALE_W_FAST = 4;
    localparam int PRESCALE_W_REAL = 16;

endpackage

// File: rtl/cadence_prescale.sv
// Free-running PW-bit prescaler; tick is high while the count is all-ones,
// clr restarts the count from zero on the next edge.
module cadence_prescale #(
    parameter int PW = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    assign tick = &cnt;

endmodule

// File: rtl/cadence_meas.sv
// Pedal cadence period measurement: counts prescale ticks between rising
// edges of the filtered cadence input and reports the period or a stall.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CAD_IDLE  | no reference edge yet; first rise starts a measurement
// CAD_MEAS  | timing from the last rise; each rise captures a period
// CAD_STALL | period counter ran out; waiting for a rise to restart
module cadence_meas
    import ebike_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cadence_filt,
    output logic [7:0] cadence_per,
    output logic       cadence_vld,
    output logic       not_pedaling
);

    localparam int PW = (FAST_SIM != 0) ? PRESCALE_W_FAST : PRESCALE_W_REAL;

    logic       prev;
    logic       rise;
    logic       tick;
    logic [7:0] period_cnt;
    logic [7:0] cap_val;

    cad_state_t state, state_nxt;
    logic [7:0] per_nxt;
    logic       vld_nxt;
    logic       np_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= cadence_filt;
        end
    end

    assign rise = cadence_filt & ~prev;

    cadence_prescale #(
        .PW (PW)
    ) u_prescale (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rise),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= 8'd0;
        end else if (rise) begin
            period_cnt <= 8'd0;
        end else if (tick && (period_cnt != CAD_SAT)) begin
            period_cnt <= period_cnt + 8'd1;
        end
    end

    // A rise before the first tick would read as zero; report the shortest
    // legal period instead so a capture is never confused with "no data".
    assign cap_val = (period_cnt == 8'd0) ? 8'd1 : period_cnt;

    always_comb begin
        state_nxt = state;
        per_nxt   = cadence_per;
        vld_nxt   = 1'b0;
        np_nxt    = not_pedaling;
        case (state)
            CAD_IDLE: begin
                if (rise) begin
                    state_nxt = CAD_MEAS;
                end
            end
            CAD_MEAS: begin
                if (rise) begin
                    per_nxt = cap_val;
                    vld_nxt = 1'b1;
                    np_nxt  = 1'b0;
                end else if (tick && (period_cnt == CAD_MAX)) begin
                    state_nxt = CAD_STALL;
                    per_nxt   = CAD_SAT;
                    np_nxt    = 1'b1;
                end
            end
            CAD_STALL: begin
                if (rise) begin
                    state_nxt = CAD_MEAS;
                end
            end
            default: begin
                state_nxt = CAD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CAD_IDLE;
            cadence_per  <= CAD_SAT;
            cadence_vld  <= 1'b0;
            not_pedaling <= 1'b1;
        end else begin
            state        <= state_nxt;
            cadence_per  <= per_nxt;
            cadence_vld  <= vld_nxt;
            not_pedaling <= np_nxt;
        end
    end

endmodule

// File: tb/tb_cadence_meas.sv
// Bench for cadence_meas (FAST_SIM=1): directed and random pedal sequences,
// expected captures derived from rise-to-rise spacing in clocks.
module tb_cadence_meas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cadence_filt = 1'b0;
    logic [7:0] cadence_per;
    logic       cadence_vld;
    logic       not_pedaling;

    cadence_meas #(.FAST_SIM(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_filt (cadence_filt),
        .cadence_per  (cadence_per),
        .cadence_vld  (cadence_vld),
        .not_pedaling (not_pedaling)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   vld_count = 0;

    // Reference model: a period is the number of 16-clock ticks that fit
    // strictly between two rises; 4080 clocks without a rise means stall.
    bit measuring = 1'b0;
    int elapsed = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cadence_vld) begin
            exp_t e;
            vld_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_vld actual=per %0d required=no pulse at cycle %0d",
                         cadence_per, cyc);
            end else begin
                e = sb.pop_front();
                check("capture_value", int'(cadence_per), e.val);
                check("capture_cycle", cyc, e.cyc);
                check("capture_not_pedaling", int'(not_pedaling), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        elapsed++;
    endtask

    task automatic do_rise(input int hi);
        exp_t e;
        int   ticks;
        if (measuring && elapsed >= 4082) begin
            check("stall_per", int'(cadence_per), 255);
            check("stall_not_pedaling", int'(not_pedaling), 1);
        end
        if (measuring && elapsed <= 4080) begin
            ticks = (elapsed - 1) / 16;
            e.val = (ticks < 1) ? 1 : ticks;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        measuring = 1'b1;
        elapsed = 0;
        cadence_filt = 1'b1;
        repeat (hi) step();
        cadence_filt = 1'b0;
    endtask

    task automatic pedal(input int period, input int hi);
        do_rise(hi);
        repeat (period - hi) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_per", int'(cadence_per), 255);
        check("reset_not_pedaling", int'(not_pedaling), 1);
        check("reset_vld", int'(cadence_vld), 0);
        check("reset_pending", sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        measuring = 1'b0;
        elapsed = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=time %0t required=finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int period;
        int sel;

        cadence_filt = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_per", int'(cadence_per), 255);
        check("por_not_pedaling", int'(not_pedaling), 1);
        check("por_vld", int'(cadence_vld), 0);
        rst_n = 1'b1;
        repeat (5) step();

        // steady pedaling, 168 clocks per revolution
        repeat (4) pedal(168, 40);
        check("steady_per", int'(cadence_per), 10);
        check("steady_not_pedaling", int'(not_pedaling), 0);

        // stall, then two rises to recover
        repeat (4100 - 168) step();
        do_rise(40);
        repeat (128) step();
        check("stall_recover_per", int'(cadence_per), 255);
        check("stall_recover_not_pedaling", int'(not_pedaling), 1);
        pedal(168, 40);
        check("after_stall_per", int'(cadence_per), 10);
        check("after_stall_not_pedaling", int'(not_pedaling), 0);

        // clamp: rises 8 clocks apart
        repeat (4) pedal(8, 3);

        // collision at cycle 160 then a restart from zero
        pedal(160, 40);
        pedal(168, 40);
        pedal(50, 10);

        // the rise on the final tick before stall still captures 8'hFE
        pedal(4080, 40);
        pedal(4081, 40);
        pedal(20, 5);

        // reset in the middle of a measurement
        pedal(100, 10);
        pedal(100, 10);
        repeat (30) step();
        do_reset();
        repeat (5) step();
        pedal(168, 40);
        pedal(168, 40);
        pedal(30, 10);

        // noisy input: 20 transitions with short random widths
        repeat (3) step();
        base = vld_count;
        for (int i = 0; i < 10; i++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 4));
            lo = int'($urandom_range(1, 4));
            pedal(hi + lo, hi);
        end
        repeat (3) step();
        check("noisy_vld_le_10", int'((vld_count - base) <= 10), 1);

        // random cadence, including boundary and stall gaps
        for (int i = 0; i < 50; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 40)      period = int'($urandom_range(2, 64));
            else if (sel < 80) period = int'($urandom_range(65, 600));
            else if (sel < 95) period = int'($urandom_range(4075, 4086));
            else               period = int'($urandom_range(4100, 4200));
            pedal(period, int'($urandom_range(1, period - 1)));
        end
        do_rise(2);
        repeat (5) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
